// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 serial transmitter: TXDATA/STATUS register window in front
// of a small byte FIFO that feeds a START/DATA/STOP serializer.
module uart_tx_mmio #(
   parameter logic [31:0] BASE         = 32'h0000_0080,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          DEPTH        = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Hit,
   output logic        tx,
   output logic        Busy
);

   localparam int             PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int             BW        = $clog2(CLKS_PER_BIT);
   localparam logic [3:0]     DEPTH_C   = 4'(DEPTH);
   localparam logic [PW-1:0]  PTR_LAST  = PW'(DEPTH - 1);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [3:0]    count_q, count_d;
   logic          ovf_q, ovf_d;

   logic          wr_txdata, wr_status;
   logic          push, pop;
   logic          empty, full;
   logic          baud_last;
   logic [7:0]    head;
   logic [7:0]    status;
   logic          unused_bits;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   assign Hit       = (DataAdr[31:3] == BASE[31:3]);
   assign wr_txdata = MemWrite & Hit & ~DataAdr[2];
   assign wr_status = MemWrite & Hit &  DataAdr[2];

   assign empty = (count_q == 4'd0);
   assign full  = (count_q == DEPTH_C);
   assign Busy  = ~empty | (state_q != S_IDLE);

   assign status   = {ovf_q, Busy, full, empty, count_q};
   assign ReadData = (Hit & DataAdr[2]) ? {24'b0, status} : 32'b0;

   assign unused_bits = ^{DataAdr[1:0], WriteData[31:8]};

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   assign push = wr_txdata & ~full;
   assign head = mem_q[rptr_q];

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q + {3'b0, push} - {3'b0, pop};
      ovf_d   = ovf_q;
      if (push) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
      // Overflow judges fullness before the edge, so a same-edge pop does not rescue the write.
      if (wr_txdata & full)              ovf_d = 1'b1;
      else if (wr_status & WriteData[7]) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= WriteData[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // ------------------------------------------------------------------
   // Serializer
   // ------------------------------------------------------------------
   assign baud_last = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_last ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            // Chain straight into the next START so back-to-back frames have no idle gap.
            if (baud_last) begin
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // tx is registered, so it is derived from the state being entered.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed plus randomized bench for uart_tx_mmio against a queue-based frame
// timing model (CLKS_PER_BIT=4, DEPTH=8).
module tb_uart_tx_mmio;

   localparam int          CPB  = 4;
   localparam int          DEP  = 8;
   localparam logic [31:0] BASE = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Hit;
   logic        tx;
   logic        Busy;

   int tests = 0;
   int fails = 0;

   // Reference model: pending bytes, the frame on the wire and when it began.
   logic [7:0] q[$];
   logic       active = 1'b0;
   logic [7:0] cur    = 8'h00;
   int         start  = 0;
   int         ecnt   = 0;
   logic       ovf    = 1'b0;

   uart_tx_mmio #(.BASE(BASE), .CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
      .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit), .tx(tx), .Busy(Busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic exp_busy();
      return active || (q.size() != 0);
   endfunction

   function automatic logic [7:0] exp_status();
      int sz;
      sz = q.size();
      return {ovf, exp_busy(), sz == DEP, sz == 0, 4'(sz)};
   endfunction

   function automatic logic exp_tx();
      int el, b;
      if (!active) return 1'b1;
      el = ecnt - start;
      b  = el / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return cur[b-1];
      return 1'b1;
   endfunction

   task automatic model_edge(input logic mw, input logic [31:0] adr, input logic [31:0] wd);
      logic hit, wtx, wst, ok;
      int   sz;
      hit = (adr[31:3] == BASE[31:3]);
      wtx = mw && hit && !adr[2];
      wst = mw && hit && adr[2];
      sz  = q.size();
      ok  = wtx && (sz < DEP);
      if (wtx && sz == DEP) ovf = 1'b1;
      else if (wst && wd[7]) ovf = 1'b0;
      ecnt++;
      if (active && (ecnt - start) == 10 * CPB) active = 1'b0;
      if (!active && sz > 0) begin
         cur    = q.pop_front();
         active = 1'b1;
         start  = ecnt;
      end
      if (ok) q.push_back(wd[7:0]);
   endtask

   // One bus cycle: check combinational read side, clock, then check the line.
   task automatic cycle(input logic mw, input logic [31:0] adr, input logic [31:0] wd);
      logic        h;
      logic [31:0] rd;
      MemWrite  = mw;
      DataAdr   = adr;
      WriteData = wd;
      #2;
      h  = (adr[31:3] == BASE[31:3]);
      rd = (h && adr[2]) ? {24'b0, exp_status()} : 32'b0;
      chk("hit", {31'b0, Hit}, {31'b0, h});
      chk("rdata", ReadData, rd);
      @(posedge clk);
      model_edge(mw, adr, wd);
      #1;
      chk("tx", {31'b0, tx}, {31'b0, exp_tx()});
      chk("busy", {31'b0, Busy}, {31'b0, exp_busy()});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0000_0000, 32'h0);
   endtask

   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (exp_busy() && guard < 2000) begin
         cycle(1'b0, 32'h0000_0084, 32'h0);
         guard++;
      end
      chk({tag, "_drain_bound"}, {31'b0, guard >= 2000}, 32'h0);
      idle(2);
   endtask

   task automatic peek_status(input string tag, input logic [31:0] exp);
      MemWrite = 1'b0;
      DataAdr  = 32'h0000_0084;
      #2;
      chk(tag, ReadData, exp);
   endtask

   task automatic mid_reset();
      MemWrite = 1'b0;
      DataAdr  = 32'h0;
      #2;
      reset = 1'b0;
      #1;
      chk("rst_tx_async", {31'b0, tx}, 32'h1);
      chk("rst_busy", {31'b0, Busy}, 32'h0);
      q.delete();
      active = 1'b0;
      ovf    = 1'b0;
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      MemWrite  = 1'b0;
      DataAdr   = 32'h0;
      WriteData = 32'h0;
      #12;
      chk("reset_tx", {31'b0, tx}, 32'h1);
      chk("reset_busy", {31'b0, Busy}, 32'h0);
      peek_status("reset_status", 32'h10);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single frame of 0x55: ten alternating bits, idle after 40 cycles.
      cycle(1'b1, 32'h0000_0080, 32'h55);
      chk("f55_tx_still_idle", {31'b0, tx}, 32'h1);
      cycle(1'b0, 32'h0, 32'h0);
      chk("f55_start_low", {31'b0, tx}, 32'h0);
      idle(39);
      chk("f55_busy_last", {31'b0, Busy}, 32'h1);
      idle(1);
      chk("f55_idle_after", {31'b0, Busy}, 32'h0);
      idle(3);

      // Three back-to-back frames.
      cycle(1'b1, 32'h0000_0080, 32'h41);
      cycle(1'b1, 32'h0000_0080, 32'h42);
      cycle(1'b1, 32'h0000_0080, 32'h43);
      drain("abc");
      peek_status("abc_status", 32'h10);

      // Ten writes during one frame: 1 popped, 8 queued, 1 dropped.
      for (int i = 0; i < 10; i++) cycle(1'b1, 32'h0000_0080, 32'(8'h30 + i));
      peek_status("ovf_status", 32'hE8);
      cycle(1'b1, 32'h0000_0084, 32'h80);
      peek_status("ovf_cleared", 32'h68);
      drain("ovf");

      // Push on the STOP edge that pops while the FIFO is full.
      for (int i = 0; i < 9; i++) cycle(1'b1, 32'h0000_0080, 32'(8'hA0 + i));
      begin
         int guard;
         guard = 0;
         while (!(active && (ecnt + 1 - start) == 10 * CPB) && guard < 100) begin
            idle(1);
            guard++;
         end
         chk("stoppop_bound", {31'b0, guard >= 100}, 32'h0);
      end
      cycle(1'b1, 32'h0000_0080, 32'h99);
      peek_status("stoppop_status", 32'hC7);
      cycle(1'b1, 32'h0000_0084, 32'h80);
      drain("stoppop");

      // Unselected address with MemWrite is ignored.
      cycle(1'b1, 32'h0000_0060, 32'hFF);
      chk("miss_hit", {31'b0, Hit}, 32'h0);
      chk("miss_rdata", ReadData, 32'h0);
      peek_status("miss_status", 32'h10);

      // Reset during DATA bit 3 aborts the frame and empties the FIFO.
      cycle(1'b1, 32'h0000_0080, 32'hC3);
      cycle(1'b1, 32'h0000_0080, 32'h3C);
      idle(17);
      mid_reset();
      peek_status("rst_status", 32'h10);
      idle(50);

      // Randomized traffic.
      for (int i = 0; i < 900; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 10)      cycle(1'b1, 32'h0000_0080, $urandom);
         else if (r < 13) cycle(1'b1, 32'h0000_0084, $urandom);
         else if (r < 20) begin
            logic [31:0] adrs[4];
            adrs = '{32'h60, 32'h88, 32'h7C, 32'h180};
            cycle(1'b1, adrs[$urandom_range(0, 3)], $urandom);
         end
         else if (r < 30) cycle(1'b0, 32'h0000_0084, $urandom);
         else             cycle(1'b0, 32'h0000_0080, $urandom);
      end
      drain("rand");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
